// File: rtl/freq_sequencer.sv
// Run/stop, manual stepping and automatic sweep control for the clock-rate selector.
// Every rate change while running drops enable for GAP_CYCLES so the selector restarts in phase.
module freq_sequencer #(
  parameter int unsigned DWELL_CYCLES = 25000000,
  parameter int unsigned GAP_CYCLES   = 2,
  parameter int unsigned CNT_BITS     = 25
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       btn_run,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic       enable,
  output logic [1:0] frecuency,
  output logic       sweep_active,
  output logic       freq_changed
);

  localparam int unsigned GAP_BITS = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CNT_BITS-1:0] DWELL_LAST = CNT_BITS'(DWELL_CYCLES - 1);
  localparam logic [GAP_BITS-1:0] GAP_LOAD   = GAP_BITS'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_STOPPED = 2'd0,
    ST_RUN     = 2'd1,
    ST_GAP     = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [1:0]          freq_q, freq_d;
  logic                en_q, en_d;
  logic                sweep_q, sweep_d;
  logic                chg_q, chg_d;
  logic [CNT_BITS-1:0] dwell_q, dwell_d;
  logic [GAP_BITS-1:0] gap_q, gap_d;

  logic mode_act_s, up_s, dn_s, can_up_s, can_dn_s;

  // Resolve button priority and manual-step qualification.
  always_comb begin
    mode_act_s = btn_mode & ~btn_run;
    up_s       = btn_up & ~btn_down & ~sweep_q & ~btn_run & ~btn_mode;
    dn_s       = btn_down & ~btn_up & ~sweep_q & ~btn_run & ~btn_mode;
    can_up_s   = (freq_q != 2'd3);
    can_dn_s   = (freq_q != 2'd0);
  end

  // Next-state and next-output computation.
  always_comb begin
    state_d = state_q;
    freq_d  = freq_q;
    en_d    = en_q;
    sweep_d = sweep_q;
    chg_d   = 1'b0;
    dwell_d = dwell_q;
    gap_d   = gap_q;

    if (mode_act_s) begin
      sweep_d = ~sweep_q;
      if (!sweep_q) begin
        dwell_d = '0;
      end else begin
        dwell_d = dwell_q;
      end
    end else begin
      sweep_d = sweep_q;
    end

    case (state_q)
      ST_STOPPED: begin
        en_d = 1'b0;
        // enable is already low, so steps apply directly; chg_q gate keeps pulses apart
        if (btn_run) begin
          state_d = ST_RUN;
          en_d    = 1'b1;
          dwell_d = '0;
        end else if (up_s && can_up_s && !chg_q) begin
          freq_d = freq_q + 2'd1;
          chg_d  = 1'b1;
        end else if (dn_s && can_dn_s && !chg_q) begin
          freq_d = freq_q - 2'd1;
          chg_d  = 1'b1;
        end else begin
          state_d = ST_STOPPED;
        end
      end
      ST_RUN: begin
        en_d = 1'b1;
        if (btn_run) begin
          state_d = ST_STOPPED;
          en_d    = 1'b0;
        end else if (mode_act_s) begin
          state_d = ST_RUN;
        end else if (sweep_q) begin
          if (dwell_q == DWELL_LAST) begin
            freq_d  = freq_q + 2'd1;
            chg_d   = 1'b1;
            dwell_d = '0;
            gap_d   = GAP_LOAD;
            state_d = ST_GAP;
            en_d    = 1'b0;
          end else begin
            dwell_d = dwell_q + CNT_BITS'(1);
          end
        end else if (up_s && can_up_s) begin
          freq_d  = freq_q + 2'd1;
          chg_d   = 1'b1;
          gap_d   = GAP_LOAD;
          state_d = ST_GAP;
          en_d    = 1'b0;
        end else if (dn_s && can_dn_s) begin
          freq_d  = freq_q - 2'd1;
          chg_d   = 1'b1;
          gap_d   = GAP_LOAD;
          state_d = ST_GAP;
          en_d    = 1'b0;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_GAP: begin
        en_d    = 1'b0;
        dwell_d = '0;
        if (btn_run) begin
          state_d = ST_STOPPED;
        end else if (gap_q == '0) begin
          state_d = ST_RUN;
          en_d    = 1'b1;
        end else begin
          gap_d = gap_q - GAP_BITS'(1);
        end
      end
      default: begin
        state_d = ST_STOPPED;
        en_d    = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= ST_STOPPED;
      freq_q  <= 2'd0;
      en_q    <= 1'b0;
      sweep_q <= 1'b0;
      chg_q   <= 1'b0;
      dwell_q <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      freq_q  <= freq_d;
      en_q    <= en_d;
      sweep_q <= sweep_d;
      chg_q   <= chg_d;
      dwell_q <= dwell_d;
      gap_q   <= gap_d;
    end
  end

  assign enable       = en_q;
  assign frecuency    = freq_q;
  assign sweep_active = sweep_q;
  assign freq_changed = chg_q;

endmodule

// File: tb/tb_freq_sequencer.sv
// Directed bench for freq_sequencer with DWELL_CYCLES=8, GAP_CYCLES=2.
// Outputs are compared as {enable, frecuency, sweep_active, freq_changed}.
module tb_freq_sequencer;

  logic       CLK = 1'b0;
  logic       RESET_N = 1'b0;
  logic       btn_run = 1'b0, btn_mode = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
  logic       enable, sweep_active, freq_changed;
  logic [1:0] frecuency;
  logic [4:0] obs_s;
  int         checks = 0;
  int         failures = 0;

  freq_sequencer #(.DWELL_CYCLES(8), .GAP_CYCLES(2), .CNT_BITS(4)) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .btn_run(btn_run), .btn_mode(btn_mode), .btn_up(btn_up), .btn_down(btn_down),
    .enable(enable), .frecuency(frecuency),
    .sweep_active(sweep_active), .freq_changed(freq_changed)
  );

  always #5 CLK = ~CLK;
  assign obs_s = {enable, frecuency, sweep_active, freq_changed};

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RESET_N = 1'b0;
    tick(); tick();
    RESET_N = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (obs_s !== 5'b0_00_0_0) begin
        failures++; $display("FAIL reset_idle cyc=%0d obs=%b exp=%b", i, obs_s, 5'b0_00_0_0);
      end
    end
  endtask

  task automatic test_manual_stopped();
    logic [1:0] exp_f;
    int pulses = 0;
    for (int i = 0; i < 4; i++) begin
      exp_f = (i < 3) ? 2'(i + 1) : 2'd3;
      btn_up = 1'b1; tick(); btn_up = 1'b0;
      if (freq_changed === 1'b1) pulses++;
      checks++;
      if (obs_s !== {1'b0, exp_f, 1'b0, (i < 3)}) begin
        failures++; $display("FAIL stopped_up%0d obs=%b exp=%b", i, obs_s, {1'b0, exp_f, 1'b0, (i < 3)});
      end
      tick();
      if (freq_changed === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 3) begin
      failures++; $display("FAIL stopped_pulses got=%0d exp=3", pulses);
    end
  endtask

  task automatic test_run_gap();
    logic [1:0] f;
    btn_run = 1'b1; tick(); btn_run = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (obs_s !== 5'b1_11_0_0) begin
        failures++; $display("FAIL run_high%0d obs=%b exp=%b", i, obs_s, 5'b1_11_0_0);
      end
      if (i < 4) tick();
    end
    // step down 3->2->1->0, each with a two-cycle enable-low gap
    for (int s = 0; s < 3; s++) begin
      f = 2'(2 - s);
      btn_down = 1'b1; tick(); btn_down = 1'b0;
      checks++;
      if (obs_s !== {1'b0, f, 2'b01}) begin
        failures++; $display("FAIL gap_first%0d obs=%b exp=%b", s, obs_s, {1'b0, f, 2'b01});
      end
      tick();
      checks++;
      if (obs_s !== {1'b0, f, 2'b00}) begin
        failures++; $display("FAIL gap_second%0d obs=%b exp=%b", s, obs_s, {1'b0, f, 2'b00});
      end
      tick();
      checks++;
      if (obs_s !== {1'b1, f, 2'b00}) begin
        failures++; $display("FAIL gap_end%0d obs=%b exp=%b", s, obs_s, {1'b1, f, 2'b00});
      end
    end
    btn_down = 1'b1; tick(); btn_down = 1'b0;
    checks++;
    if (obs_s !== 5'b1_00_0_0) begin
      failures++; $display("FAIL run_down_sat obs=%b exp=%b", obs_s, 5'b1_00_0_0);
    end
    tick();
    checks++;
    if (obs_s !== 5'b1_00_0_0) begin
      failures++; $display("FAIL run_down_sat2 obs=%b exp=%b", obs_s, 5'b1_00_0_0);
    end
  endtask

  task automatic test_sweep();
    logic [1:0] codes [0:4];
    codes = '{2'd2, 2'd3, 2'd0, 2'd1, 2'd2};
    btn_run = 1'b1; tick(); btn_run = 1'b0;
    btn_up = 1'b1; tick(); btn_up = 1'b0; tick();
    btn_up = 1'b1; tick(); btn_up = 1'b0; tick();
    checks++;
    if (obs_s !== 5'b0_10_0_0) begin
      failures++; $display("FAIL sweep_setup obs=%b exp=%b", obs_s, 5'b0_10_0_0);
    end
    btn_mode = 1'b1; tick(); btn_mode = 1'b0;
    checks++;
    if (obs_s !== 5'b0_10_1_0) begin
      failures++; $display("FAIL mode_on obs=%b exp=%b", obs_s, 5'b0_10_1_0);
    end
    btn_run = 1'b1; tick(); btn_run = 1'b0;
    for (int c = 0; c < 4; c++) begin
      for (int j = 0; j < 8; j++) begin
        checks++;
        if (obs_s !== {1'b1, codes[c], 2'b10}) begin
          failures++; $display("FAIL dwell c%0d j%0d obs=%b exp=%b", c, j, obs_s, {1'b1, codes[c], 2'b10});
        end
        tick();
      end
      checks++;
      if (obs_s !== {1'b0, codes[c+1], 2'b11}) begin
        failures++; $display("FAIL sweep_step%0d obs=%b exp=%b", c, obs_s, {1'b0, codes[c+1], 2'b11});
      end
      if (c < 3) begin
        tick();
        checks++;
        if (obs_s !== {1'b0, codes[c+1], 2'b10}) begin
          failures++; $display("FAIL sweep_gap%0d obs=%b exp=%b", c, obs_s, {1'b0, codes[c+1], 2'b10});
        end
        tick();
      end
    end
  endtask

  task automatic test_stop_in_gap();
    btn_run = 1'b1; tick(); btn_run = 1'b0;
    checks++;
    if (obs_s !== 5'b0_10_1_0) begin
      failures++; $display("FAIL gap_stop obs=%b exp=%b", obs_s, 5'b0_10_1_0);
    end
    tick();
    checks++;
    if (obs_s !== 5'b0_10_1_0) begin
      failures++; $display("FAIL gap_stop_hold obs=%b exp=%b", obs_s, 5'b0_10_1_0);
    end
    btn_up = 1'b1; tick(); btn_up = 1'b0;
    checks++;
    if (obs_s !== 5'b0_10_1_0) begin
      failures++; $display("FAIL sweep_up_ignored obs=%b exp=%b", obs_s, 5'b0_10_1_0);
    end
    tick();
    btn_down = 1'b1; tick(); btn_down = 1'b0;
    checks++;
    if (obs_s !== 5'b0_10_1_0) begin
      failures++; $display("FAIL sweep_down_ignored obs=%b exp=%b", obs_s, 5'b0_10_1_0);
    end
  endtask

  task automatic test_coincident();
    btn_mode = 1'b1; tick(); btn_mode = 1'b0;
    btn_run = 1'b1; tick(); btn_run = 1'b0;
    checks++;
    if (obs_s !== 5'b1_10_0_0) begin
      failures++; $display("FAIL manual_run obs=%b exp=%b", obs_s, 5'b1_10_0_0);
    end
    btn_up = 1'b1; btn_down = 1'b1; tick(); btn_up = 1'b0; btn_down = 1'b0;
    checks++;
    if (obs_s !== 5'b1_10_0_0) begin
      failures++; $display("FAIL up_down_same obs=%b exp=%b", obs_s, 5'b1_10_0_0);
    end
    btn_run = 1'b1; btn_up = 1'b1; tick(); btn_run = 1'b0; btn_up = 1'b0;
    checks++;
    if (obs_s !== 5'b0_10_0_0) begin
      failures++; $display("FAIL run_beats_up obs=%b exp=%b", obs_s, 5'b0_10_0_0);
    end
    tick();
    checks++;
    if (obs_s !== 5'b0_10_0_0) begin
      failures++; $display("FAIL run_beats_up2 obs=%b exp=%b", obs_s, 5'b0_10_0_0);
    end
  endtask

  task automatic test_reset_mid_gap();
    btn_run = 1'b1; tick(); btn_run = 1'b0;
    btn_up = 1'b1; tick(); btn_up = 1'b0;
    checks++;
    if (obs_s !== 5'b0_11_0_1) begin
      failures++; $display("FAIL pre_reset_gap obs=%b exp=%b", obs_s, 5'b0_11_0_1);
    end
    btn_mode = 1'b1; tick(); btn_mode = 1'b0;
    checks++;
    if (obs_s !== 5'b0_11_1_0) begin
      failures++; $display("FAIL mode_in_gap obs=%b exp=%b", obs_s, 5'b0_11_1_0);
    end
    #2 RESET_N = 1'b0;
    #1;
    checks++;
    if (obs_s !== 5'b0_00_0_0) begin
      failures++; $display("FAIL async_reset obs=%b exp=%b", obs_s, 5'b0_00_0_0);
    end
    tick();
    RESET_N = 1'b1;
    tick();
    checks++;
    if (obs_s !== 5'b0_00_0_0) begin
      failures++; $display("FAIL post_reset obs=%b exp=%b", obs_s, 5'b0_00_0_0);
    end
  endtask

  initial begin
    test_reset();
    test_manual_stopped();
    test_run_gap();
    test_sweep();
    test_stop_in_gap();
    test_coincident();
    test_reset_mid_gap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/freq_sequencer.md
Name: freq_sequencer

Overview:
- Control block for the signal generator's clock-rate selector. It drives the selector's `enable` and 2-bit `frecuency` code.
- Turns single-cycle, already-debounced button pulses into run/stop, manual up/down stepping and an automatic sweep through all four rates.
- On every rate change while running, it drops `enable` for a short gap. Because `enable` low resets the selector's counters, the new rate starts from a clean phase.

Parameters:
- DWELL_CYCLES, default 25000000: CLK cycles spent at each code in sweep mode (min 2).
- GAP_CYCLES, default 2: CLK cycles `enable` is held low after a rate change while running (min 1).
- CNT_BITS, default 25: width of the dwell counter; must satisfy 2^CNT_BITS > DWELL_CYCLES.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RESET_N  input  1  asynchronous active-low reset.
- btn_run  input  1  1-cycle pulse; toggles run/stop.
- btn_mode  input  1  1-cycle pulse; toggles manual/sweep mode.
- btn_up  input  1  1-cycle pulse; next higher code (manual only).
- btn_down  input  1  1-cycle pulse; next lower code (manual only).
- enable  output  1  to selector `enable`; registered.
- frecuency  output  2  to selector `frecuency`; registered.
- sweep_active  output  1  1 = sweep mode selected; registered.
- freq_changed  output  1  1-cycle pulse in the cycle after `frecuency` updates; registered.

Behaviour:
- Reset (async assert, sync release):
  - state = STOPPED.
  - frecuency = 2'b00, enable = 0, sweep_active = 0, freq_changed = 0.
  - Dwell counter = 0, gap counter = 0.
- States: STOPPED, RUN, GAP. All outputs are registered: a pulse sampled at edge k is reflected on the outputs after edge k.
- Input priority when pulses coincide: btn_run > btn_mode > btn_up/btn_down.
  - btn_up and btn_down in the same cycle: both ignored.
  - Lower-priority pulses in a cycle where btn_run acts are ignored.
- Mode toggle:
  - btn_mode toggles sweep_active in any state.
  - Entering sweep clears the dwell counter.
  - Never changes frecuency.
- STOPPED:
  - enable = 0.
  - Manual up/down change frecuency immediately, saturating at 3 and 0. No gap is needed because `enable` is already low.
  - freq_changed pulses only when the value actually changes.
  - btn_run -> RUN: enable = 1, dwell counter cleared.
- RUN:
  - enable = 1.
  - btn_run -> STOPPED: enable = 0 next cycle.
  - Manual mode: btn_up when frecuency < 3, or btn_down when frecuency > 0 -> frecuency updated on the same edge, gap counter loaded, -> GAP.
  - Manual mode at saturation (up at 3, down at 0): ignored; stays in RUN, no gap, no freq_changed.
  - Sweep mode: up/down ignored.
    - Dwell counter increments every cycle in RUN.
    - When it equals DWELL_CYCLES-1: frecuency = frecuency+1 mod 4 (3 wraps to 0), counter cleared, -> GAP.
- GAP:
  - enable = 0 for exactly GAP_CYCLES cycles, then -> RUN with enable = 1. The dwell counter stays at 0 during GAP.
  - btn_run in GAP -> STOPPED immediately; frecuency keeps its new value.
  - btn_up/btn_down in GAP are ignored.
  - btn_mode in GAP toggles the mode; the gap still completes.
- freq_changed:
  - High for one cycle after every frecuency update (manual or sweep).
  - Never high for two consecutive cycles.
  - Low throughout and after reset.
- Reset asserted in any state, including mid-GAP or mid-dwell, immediately forces all reset values.

Test Plan (bench parameters: DWELL_CYCLES=8, GAP_CYCLES=2):
- Reset then idle 10 cycles -> enable=0, frecuency=0, sweep_active=0, freq_changed=0 throughout.
- STOPPED, btn_up x4 (separate cycles) -> frecuency 1, 2, 3, 3. freq_changed pulses 3 times. enable stays 0.
- btn_run, then btn_down 5 cycles later -> enable=1. Then, after the btn_down edge: frecuency 3->2, enable=0 for exactly 2 cycles then 1, one freq_changed pulse. Then btn_down at frecuency=0 -> no gap, no pulse.
- btn_mode then btn_run from frecuency=2 -> code sequence 2,3,0,1. Each code lasts 8 enable-high cycles plus a 2-cycle enable-low gap. 3 wraps to 0.
- Sweep running, btn_run during GAP -> STOPPED next cycle, enable stays 0, frecuency holds the new code. btn_up/btn_down ignored while sweep_active=1.
- btn_up and btn_down in the same cycle in RUN -> no change. btn_run+btn_up same cycle -> only the stop takes effect. RESET_N low mid-GAP -> all outputs to reset values without waiting for a CLK edge.
